// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hazard_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; the pipeline is master, the controller is slave.
interface hazard_ctrl_if;

  logic [4:0] RsD, RtD, RsE, RtE;
  logic       BranchD;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, MemtoRegE;
  logic       RegWriteM, MemtoRegM;
  logic       RegWriteW;
  logic       MemReqM, MemReadyM;

  logic       StallF, StallD, StallE, StallM, StallW;
  logic       FlushE;
  logic       ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;

  modport master (
    output RsD, RtD, RsE, RtE, BranchD,
    output WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW,
    output MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, StallW, FlushE,
    input  ForwardAD, ForwardBD, ForwardAE, ForwardBE
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, BranchD,
    input  WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW,
    input  MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, StallW, FlushE,
    output ForwardAD, ForwardBD, ForwardAE, ForwardBE
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding selects for the E-stage ALU operands and the D-stage branch comparator.
module hazard_fwd_unit
  import mips_pkg::*;
(
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegM,
  input  logic       RegWriteM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteW,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  logic m_hit_ae, w_hit_ae, m_hit_be, w_hit_be;

  // Register $0 is hard-wired zero, so it is never a forwarding target.
  assign m_hit_ae = (RsE != 5'd0) && RegWriteM && (WriteRegM == RsE);
  assign w_hit_ae = (RsE != 5'd0) && RegWriteW && (WriteRegW == RsE);
  assign m_hit_be = (RtE != 5'd0) && RegWriteM && (WriteRegM == RtE);
  assign w_hit_be = (RtE != 5'd0) && RegWriteW && (WriteRegW == RtE);

  // The M-stage result is younger than W, so it takes priority.
  assign ForwardAE = m_hit_ae ? FWD_MEM : (w_hit_ae ? FWD_WB : FWD_RF);
  assign ForwardBE = m_hit_be ? FWD_MEM : (w_hit_be ? FWD_WB : FWD_RF);

  assign ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
  assign ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipe: load-use/branch stalls, forwarding, data-memory freeze and
// timeout trap. Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  hazard_ctrl_if.slave     hz,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int                WC_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0]   WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  hazard_state_t   state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            mem_miss, lwstall, brstall, memstall;
  logic            fwd_ad, fwd_bd;
  logic [1:0]      fwd_ae, fwd_be;

  hazard_fwd_unit u_fwd (
    .RsD       (hz.RsD),
    .RtD       (hz.RtD),
    .RsE       (hz.RsE),
    .RtE       (hz.RtE),
    .WriteRegM (hz.WriteRegM),
    .RegWriteM (hz.RegWriteM),
    .WriteRegW (hz.WriteRegW),
    .RegWriteW (hz.RegWriteW),
    .ForwardAD (fwd_ad),
    .ForwardBD (fwd_bd),
    .ForwardAE (fwd_ae),
    .ForwardBE (fwd_be)
  );

  assign mem_miss = hz.MemReqM && !hz.MemReadyM;

  assign lwstall = hz.MemtoRegE && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));

  assign brstall = hz.BranchD &&
                   ((hz.RegWriteE && ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
                    (hz.MemtoRegM && ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));

  assign memstall = (state == ERR) || (((state == RUN) || (state == MEM_WAIT)) && mem_miss);

  // Everything is gated by Reset so the pipe sees no stall/flush/forward while reset is held.
  assign hz.StallF    = Reset && (lwstall || brstall || memstall);
  assign hz.StallD    = Reset && (lwstall || brstall || memstall);
  assign hz.StallE    = Reset && memstall;
  assign hz.StallM    = Reset && memstall;
  assign hz.StallW    = Reset && memstall;
  assign hz.FlushE    = Reset && (lwstall || brstall) && !memstall;
  assign hz.ForwardAD = Reset && fwd_ad;
  assign hz.ForwardBD = Reset && fwd_bd;
  assign hz.ForwardAE = Reset ? fwd_ae : FWD_RF;
  assign hz.ForwardBE = Reset ? fwd_be : FWD_RF;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_miss) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        // A dropped request ends the wait just like a ready.
        if (!mem_miss) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WC_LAST) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WC_W'(1);
        end
      end
      ERR: state_nxt = ERR;
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= RUN;
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ERR) MemTimeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (hz.StallF && (StallCount != '1)) StallCount <= StallCount + CNT_W'(1);
      if (hz.FlushE && (FlushCount != '1)) FlushCount <= FlushCount + CNT_W'(1);
    end
  end
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4); counter expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;
  import mips_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             Reset;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int vectors    = 0;
  int miscompares = 0;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .hz         (hz.slave),
    .MemTimeout (MemTimeout),
    .StallCount (StallCount),
    .FlushCount (FlushCount)
  );

  always #5 CLK = ~CLK;

  // {StallF, StallD, StallE, StallM, StallW, FlushE}
  logic [5:0] sv;
  assign sv = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW, hz.FlushE};

  task automatic clear_inputs();
    hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0; hz.BranchD = 0;
    hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
    hz.RegWriteE = 0; hz.MemtoRegE = 0; hz.RegWriteM = 0; hz.MemtoRegM = 0; hz.RegWriteW = 0;
    hz.MemReqM = 0; hz.MemReadyM = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1'b0;
    hz.MemtoRegE = 1; hz.RtE = 8; hz.RsD = 8;
    hz.RsE = 5; hz.RegWriteM = 1; hz.WriteRegM = 5; hz.MemReqM = 1;
    #1;
    vectors++;
    if (sv !== 6'b000000) begin
      miscompares++; $display("FAIL reset_stalls: got %b expected %b", sv, 6'b000000);
    end
    vectors++;
    if ({hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD} !== 6'b0) begin
      miscompares++; $display("FAIL reset_fwd: got %b expected 000000",
                              {hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD});
    end
    vectors++;
    if ({MemTimeout, StallCount, FlushCount} !== '0 || dut.state !== RUN) begin
      miscompares++; $display("FAIL reset_state: timeout=%b sc=%0d fc=%0d state=%0d expected 0/0/0/RUN",
                              MemTimeout, StallCount, FlushCount, dut.state);
    end
    clear_inputs();
    @(negedge CLK) Reset = 1'b1;
  endtask

  task automatic test_forward_e();
    @(negedge CLK);
    clear_inputs();
    hz.RsE = 5; hz.RtE = 5; hz.RegWriteM = 1; hz.WriteRegM = 5; hz.RegWriteW = 1; hz.WriteRegW = 5;
    #1;
    vectors++;
    if (hz.ForwardAE !== 2'b10 || hz.ForwardBE !== 2'b10) begin
      miscompares++; $display("FAIL fwd_m_priority: AE=%b BE=%b expected 10/10", hz.ForwardAE, hz.ForwardBE);
    end
    hz.RegWriteM = 0;
    #1;
    vectors++;
    if (hz.ForwardAE !== 2'b01 || hz.ForwardBE !== 2'b01) begin
      miscompares++; $display("FAIL fwd_w: AE=%b BE=%b expected 01/01", hz.ForwardAE, hz.ForwardBE);
    end
    hz.RsE = 0;
    #1;
    vectors++;
    if (hz.ForwardAE !== 2'b00 || hz.ForwardBE !== 2'b01) begin
      miscompares++; $display("FAIL fwd_r0: AE=%b BE=%b expected 00/01", hz.ForwardAE, hz.ForwardBE);
    end
    vectors++;
    if (sv !== 6'b000000) begin
      miscompares++; $display("FAIL fwd_no_stall: got %b expected 000000", sv);
    end
  endtask

  task automatic test_lwstall();
    @(negedge CLK);
    clear_inputs();
    hz.MemtoRegE = 1; hz.RtE = 8; hz.RsD = 8;
    #1;
    vectors++;
    if (sv !== 6'b110001) begin
      miscompares++; $display("FAIL lwstall: got %b expected %b", sv, 6'b110001);
    end
    @(negedge CLK);
    hz.MemtoRegE = 0;
    #1;
    vectors++;
    if (sv !== 6'b000000) begin
      miscompares++; $display("FAIL lwstall_release: got %b expected 000000", sv);
    end
  endtask

  task automatic test_branch();
    @(negedge CLK);
    clear_inputs();
    hz.BranchD = 1; hz.RsD = 3; hz.RtD = 7; hz.RegWriteE = 1; hz.WriteRegE = 3;
    #1;
    vectors++;
    if (sv !== 6'b110001) begin
      miscompares++; $display("FAIL brstall_e: got %b expected %b", sv, 6'b110001);
    end
    hz.RegWriteE = 0; hz.MemtoRegM = 1; hz.WriteRegM = 3;
    #1;
    vectors++;
    if (sv !== 6'b110001 || hz.ForwardAD !== 1'b0) begin
      miscompares++; $display("FAIL brstall_m_load: got %b fad=%b expected 110001 fad=0", sv, hz.ForwardAD);
    end
    hz.MemtoRegM = 0; hz.RegWriteM = 1; hz.WriteRegM = 3;
    #1;
    vectors++;
    if (sv !== 6'b000000 || hz.ForwardAD !== 1'b1 || hz.ForwardBD !== 1'b0) begin
      miscompares++; $display("FAIL br_fwd_ad: got %b fad=%b fbd=%b expected 000000 1 0",
                              sv, hz.ForwardAD, hz.ForwardBD);
    end
    hz.WriteRegM = 7;
    #1;
    vectors++;
    if (hz.ForwardAD !== 1'b0 || hz.ForwardBD !== 1'b1) begin
      miscompares++; $display("FAIL br_fwd_bd: fad=%b fbd=%b expected 0 1", hz.ForwardAD, hz.ForwardBD);
    end
  endtask

  task automatic test_mem_wait();
    @(negedge CLK);
    clear_inputs();
    hz.MemReqM = 1; hz.MemReadyM = 0; hz.MemtoRegE = 1; hz.RtE = 8; hz.RsD = 8;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (sv !== 6'b111110) begin
        miscompares++; $display("FAIL mem_freeze_cyc%0d: got %b expected 111110", i, sv);
      end
      @(negedge CLK);
    end
    hz.MemReadyM = 1; hz.MemtoRegE = 0;
    #1;
    vectors++;
    if (sv !== 6'b000000 || dut.state !== MEM_WAIT) begin
      miscompares++; $display("FAIL mem_ready: got %b state=%0d expected 000000 MEM_WAIT", sv, dut.state);
    end
    @(negedge CLK);
    #1;
    vectors++;
    if (dut.state !== RUN || MemTimeout !== 1'b0) begin
      miscompares++; $display("FAIL mem_back_to_run: state=%0d timeout=%b expected RUN 0", dut.state, MemTimeout);
    end
    clear_inputs();
  endtask

  task automatic test_req_drop();
    @(negedge CLK);
    clear_inputs();
    hz.MemReqM = 1; hz.MemReadyM = 0;
    @(negedge CLK);
    hz.MemReqM = 0;
    #1;
    vectors++;
    if (sv !== 6'b000000 || dut.state !== MEM_WAIT) begin
      miscompares++; $display("FAIL req_drop: got %b state=%0d expected 000000 MEM_WAIT", sv, dut.state);
    end
    @(negedge CLK);
    #1;
    vectors++;
    if (dut.state !== RUN) begin
      miscompares++; $display("FAIL req_drop_run: state=%0d expected RUN", dut.state);
    end
  endtask

  task automatic test_timeout();
    @(negedge CLK);
    clear_inputs();
    hz.MemReqM = 1; hz.MemReadyM = 0; hz.MemtoRegE = 1; hz.RtE = 8; hz.RsD = 8;
    for (int e = 1; e <= 4; e++) begin
      @(negedge CLK);
      #1;
      vectors++;
      if (MemTimeout !== (e == 4) || sv !== 6'b111110) begin
        miscompares++; $display("FAIL timeout_edge%0d: timeout=%b stalls=%b expected %b 111110",
                                e, MemTimeout, sv, (e == 4));
      end
    end
    hz.MemReadyM = 1;
    #1;
    vectors++;
    if (sv !== 6'b111110 || dut.state !== ERR) begin
      miscompares++; $display("FAIL err_sticky: got %b state=%0d expected 111110 ERR", sv, dut.state);
    end
    @(negedge CLK);
    #1;
    vectors++;
    if (sv !== 6'b111110 || MemTimeout !== 1'b1) begin
      miscompares++; $display("FAIL err_hold: got %b timeout=%b expected 111110 1", sv, MemTimeout);
    end
    hz.RsE = 5; hz.RegWriteM = 1; hz.WriteRegM = 5;
    Reset = 1'b0;
    #1;
    vectors++;
    if (sv !== 6'b000000 || hz.ForwardAE !== 2'b00 || MemTimeout !== 1'b0 || dut.state !== RUN) begin
      miscompares++; $display("FAIL err_reset: stalls=%b AE=%b timeout=%b state=%0d expected 000000 00 0 RUN",
                              sv, hz.ForwardAE, MemTimeout, dut.state);
    end
    clear_inputs();
    @(negedge CLK) Reset = 1'b1;
  endtask

  task automatic test_perf();
    logic [CNT_W-1:0] exp_sc;
    logic [CNT_W-1:0] exp_fc;
    clear_inputs();
    Reset = 1'b0;
    @(negedge CLK) Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      hz.MemtoRegE = 1; hz.RtE = 8; hz.RsD = 8;
    end
    @(negedge CLK);
    clear_inputs();
    #1;
    exp_sc = PERF ? 4'd3 : 4'd0;
    exp_fc = PERF ? 4'd3 : 4'd0;
    vectors++;
    if (StallCount !== exp_sc || FlushCount !== exp_fc) begin
      miscompares++; $display("FAIL perf_3: sc=%0d fc=%0d expected %0d %0d", StallCount, FlushCount, exp_sc, exp_fc);
    end
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      hz.MemtoRegE = 1; hz.RtE = 8; hz.RsD = 8;
    end
    @(negedge CLK);
    clear_inputs();
    #1;
    exp_sc = PERF ? 4'd15 : 4'd0;
    exp_fc = PERF ? 4'd15 : 4'd0;
    vectors++;
    if (StallCount !== exp_sc || FlushCount !== exp_fc) begin
      miscompares++; $display("FAIL perf_sat: sc=%0d fc=%0d expected %0d %0d", StallCount, FlushCount, exp_sc, exp_fc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_forward_e();
    test_lwstall();
    test_branch();
    test_mem_wait();
    test_req_drop();
    test_timeout();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
